serial_pattern_tx: RTL



---
 rtl/serial_pattern_tx_pkg.sv | 17 +
 rtl/serial_pattern_tx_shift_reg.sv | 40 ++++
 rtl/serial_pattern_tx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/serial_pattern_tx_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
// The state width matches the downstream 2-bit sequence FSM.
package serial_pattern_tx_pkg;

  localparam int STATE_W   = 2;
  localparam int DEF_PAT_W = 8;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_GAP   = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/serial_pattern_tx_shift_reg.sv
// Pattern store for the transmitter: holds the bits still to be sent plus a
// hold copy of the whole pattern so later repetitions can be reloaded.
module pattern_shift_reg #(
  parameter int PAT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             reload_i,
  input  logic             shift_i,
  input  logic [PAT_W-1:0] pattern_i,
  output logic             next_msb_o,
  output logic             hold_msb_o
);

  // The MSB itself goes straight to the output flop, so only the remaining bits are kept here.
  logic [PAT_W-1:0] sr_q;
  logic [PAT_W-1:0] hold_q;

  // Load captures both copies; reload restarts from the hold copy; shift advances one bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q   <= '0;
      hold_q <= '0;
    end else if (load_i) begin
      sr_q   <= {pattern_i[PAT_W-2:0], 1'b0};
      hold_q <= pattern_i;
    end else if (reload_i) begin
      sr_q   <= {hold_q[PAT_W-2:0], 1'b0};
    end else if (shift_i) begin
      sr_q   <= {sr_q[PAT_W-2:0], 1'b0};
    end else begin
      sr_q   <= sr_q;
    end
  end

  assign next_msb_o = sr_q[PAT_W-1];
  assign hold_msb_o = hold_q[PAT_W-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: sends a parallel pattern MSB-first, repeated
// a programmed number of times with idle gaps, then pulses done for one cycle.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GAP   = DEF_GAP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [PAT_W-1:0]   pattern,
  input  logic [CNT_W-1:0]   repeats,
  output logic               x,
  output logic               x_valid,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] state
);

  localparam int BIT_CW = $clog2(PAT_W);
  localparam int GAP_CW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(PAT_W - 1);
  localparam logic [BIT_CW-1:0] BIT_ONE  = BIT_CW'(1);
  localparam logic [CNT_W-1:0]  REP_ONE  = CNT_W'(1);
  localparam logic [GAP_CW-1:0] GAP_ONE  = GAP_CW'(1);
  localparam logic [GAP_CW-1:0] GAP_LOAD = GAP_CW'((GAP > 0) ? GAP - 1 : 0);

  state_e              state_q;
  logic [BIT_CW-1:0]   bit_cnt_q;
  logic [CNT_W-1:0]    rep_left_q;
  logic [GAP_CW-1:0]   gap_cnt_q;
  logic                x_q;
  logic                x_valid_q;
  logic                busy_q;
  logic                done_q;

  logic                load_s;
  logic                shift_s;
  logic                reload_s;
  logic                last_bit_s;
  logic                next_msb_s;
  logic                hold_msb_s;

  assign last_bit_s = (bit_cnt_q == '0);
  assign load_s     = (state_q == ST_IDLE) && start && !abort;
  assign shift_s    = (state_q == ST_SHIFT) && !abort && !last_bit_s;
  // Back-to-back repetitions reload straight from SHIFT; otherwise reload when the gap expires.
  assign reload_s   = !abort &&
                      (((state_q == ST_SHIFT) && last_bit_s && (rep_left_q > REP_ONE) && (GAP == 0)) ||
                       ((state_q == ST_GAP) && (gap_cnt_q == '0)));

  pattern_shift_reg #(.PAT_W(PAT_W)) u_shift_reg (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (load_s),
    .reload_i   (reload_s),
    .shift_i    (shift_s),
    .pattern_i  (pattern),
    .next_msb_o (next_msb_s),
    .hold_msb_o (hold_msb_s)
  );

  // Transmit FSM with counters and registered outputs; x stays 0 whenever x_valid is 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rep_left_q <= '0;
      gap_cnt_q  <= '0;
      x_q        <= 1'b0;
      x_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_q    <= ST_SHIFT;
            rep_left_q <= (repeats == '0) ? REP_ONE : repeats;
            bit_cnt_q  <= BIT_LAST;
            x_q        <= pattern[PAT_W-1];
            x_valid_q  <= 1'b1;
          end else begin
            busy_q     <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
          end else if (!last_bit_s) begin
            bit_cnt_q <= bit_cnt_q - BIT_ONE;
            x_q       <= next_msb_s;
            x_valid_q <= 1'b1;
          end else if (rep_left_q > REP_ONE) begin
            rep_left_q <= rep_left_q - REP_ONE;
            if (GAP > 0) begin
              state_q   <= ST_GAP;
              gap_cnt_q <= GAP_LOAD;
            end else begin
              bit_cnt_q <= BIT_LAST;
              x_q       <= hold_msb_s;
              x_valid_q <= 1'b1;
            end
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_GAP: begin
          if (abort) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
          end else if (gap_cnt_q == '0) begin
            state_q   <= ST_SHIFT;
            bit_cnt_q <= BIT_LAST;
            x_q       <= hold_msb_s;
            x_valid_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_ONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign state   = state_q;

endmodule
